// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, j),
// with a memory wait-state timeout. Optional MC_INSTR_COUNT_EN adds a retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       memto_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       sign_or_zero,
    output logic       instr_done,
    output logic       illegal_op,
`ifdef MC_INSTR_COUNT_EN
    output logic [31:0] instr_count,
`endif
    output logic       mem_timeout
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB,
        MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_state;

    assign sign_or_zero = 1'b1;
    assign mem_state = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        memto_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                memto_reg  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // The last tolerated wait cycle aborts back to FETCH; the FETCH strobes are already
        // gated by mem_ready, so the PC stays put and the fetch is simply retried.
        if (mem_state && !mem_ready) begin
            if (wait_cnt_q == WAIT_LAST) begin
                mem_timeout = 1'b1;
                state_d     = FETCH;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] instr_count_q, instr_count_d;

    always_comb instr_count_d = instr_count_q + {31'd0, instr_done};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) instr_count_q <= '0;
        else       instr_count_q <= instr_count_d;
    end

    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven, scoreboarded bench for multicycle_controller: per-cycle control word checks
// for every instruction class, wait states, timeouts and asynchronous reset.
module tb_multicycle_controller;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, memto_reg, reg_write, alu_src_a, sign_or_zero;
    logic       instr_done, illegal_op, mem_timeout;
    logic [1:0] pc_source, alu_src_b, alu_op;
`ifdef MC_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    multicycle_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .sign_or_zero(sign_or_zero), .instr_done(instr_done), .illegal_op(illegal_op),
`ifdef MC_INSTR_COUNT_EN
        .instr_count(instr_count),
`endif
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Control word: {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
    //   reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b, alu_op, sign_or_zero,
    //   instr_done, illegal_op, mem_timeout}
    localparam logic [19:0] E_IDLE     = 20'h00008;
    localparam logic [19:0] E_FETCH    = 20'h85078;
    localparam logic [19:0] E_FETCH_W  = 20'h04078;
    localparam logic [19:0] E_FETCH_TO = 20'h04079;
    localparam logic [19:0] E_DECODE   = 20'h000F8;
    localparam logic [19:0] E_DEC_ILL  = 20'h000FA;
    localparam logic [19:0] E_MADDR    = 20'h001B8;
    localparam logic [19:0] E_MRD_W    = 20'h0C008;
    localparam logic [19:0] E_MRD_TO   = 20'h0C009;
    localparam logic [19:0] E_MWB      = 20'h0060C;
    localparam logic [19:0] E_MWR_W    = 20'h0A008;
    localparam logic [19:0] E_MWR      = 20'h0A00C;
    localparam logic [19:0] E_MWR_TO   = 20'h0A009;
    localparam logic [19:0] E_EXEC     = 20'h00108;
    localparam logic [19:0] E_ALUWB    = 20'h00A0C;
    localparam logic [19:0] E_BRANCH   = 20'h5011C;
    localparam logic [19:0] E_JUMP     = 20'hA000C;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, IL = 6'b111111;

    typedef struct {
        logic [5:0]  opc;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [19:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          model_cnt = 0;

    function automatic logic [19:0] act_word();
        return {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b, alu_op, sign_or_zero,
                instr_done, illegal_op, mem_timeout};
    endfunction

    task automatic check_word(input string name);
        logic [19:0] e;
        logic [19:0] a;
        e = sb.pop_front();
        a = act_word();
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s @%0t: control word got %05h expected %05h", name, $time, a, e);
        end
        if (e[2]) model_cnt++;
    endtask

    task automatic check_count(input string name);
`ifdef MC_INSTR_COUNT_EN
        n_vec++;
        if (instr_count !== 32'(model_cnt)) begin
            n_err++;
            $display("FAIL %s: instr_count got %0d expected %0d", name, instr_count, model_cnt);
        end
`endif
    endtask

    // Drive one cycle just after the rising edge, compare mid-cycle.
    task automatic step(input logic [5:0] opc, input logic rdy, input logic [19:0] exp,
                        input string name);
        opcode    = opc;
        mem_ready = rdy;
        sb.push_back(exp);
        @(negedge clk);
        check_word(name);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] opc, input logic rdy, input logic [19:0] exp);
        vec_t v;
        v.opc = opc; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; opcode = RT; mem_ready = 1'b0;

        // R-type, lw with 3 wait states, beq, j, illegal, FETCH waits, sw.
        add(RT, 1, E_IDLE);
        add(RT, 1, E_FETCH); add(RT, 1, E_DECODE); add(RT, 1, E_EXEC); add(RT, 1, E_ALUWB);
        add(LW, 1, E_FETCH); add(LW, 1, E_DECODE); add(LW, 1, E_MADDR);
        add(LW, 0, E_MRD_W); add(LW, 0, E_MRD_W); add(LW, 0, E_MRD_W); add(LW, 1, E_MRD_W);
        add(LW, 1, E_MWB);
        add(BQ, 1, E_FETCH); add(BQ, 1, E_DECODE); add(BQ, 1, E_BRANCH);
        add(JP, 1, E_FETCH); add(JP, 1, E_DECODE); add(JP, 1, E_JUMP);
        add(IL, 1, E_FETCH); add(IL, 1, E_DEC_ILL);
        add(SW, 0, E_FETCH_W); add(SW, 0, E_FETCH_W); add(SW, 1, E_FETCH);
        add(SW, 1, E_DECODE); add(SW, 1, E_MADDR); add(SW, 1, E_MWR);

        repeat (2) @(posedge clk);
        #1;
        opcode = RT; mem_ready = 1'b1;
        sb.push_back(E_IDLE);
        @(negedge clk);
        check_word("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i].opc, tbl[i].rdy, tbl[i].exp, $sformatf("table[%0d]", i));
        check_count("count_after_table");

        // sw stalls TO cycles: abort on the last, no instr_done, back to FETCH.
        step(SW, 1, E_FETCH, "sw_to_fetch"); step(SW, 1, E_DECODE, "sw_to_dec");
        step(SW, 1, E_MADDR, "sw_to_addr");
        for (int i = 1; i < TO; i++) step(SW, 0, E_MWR_W, $sformatf("sw_wait%0d", i));
        step(SW, 0, E_MWR_TO, "sw_timeout");
        step(SW, 0, E_FETCH_W, "sw_after_to");

        // FETCH stall timeout retries the fetch (counter restarts).
        for (int i = 2; i < TO; i++) step(RT, 0, E_FETCH_W, $sformatf("fetch_wait%0d", i));
        step(RT, 0, E_FETCH_TO, "fetch_timeout");
        step(RT, 0, E_FETCH_W, "fetch_retry");
        step(RT, 1, E_FETCH, "fetch_retry_ok");

        // lw: ready arrives on the would-be timeout cycle and wins.
        step(LW, 1, E_DECODE, "lw_dec"); step(LW, 1, E_MADDR, "lw_addr");
        for (int i = 1; i < TO; i++) step(LW, 0, E_MRD_W, $sformatf("lw_wait%0d", i));
        step(LW, 1, E_MRD_W, "lw_ready_at_limit");
        step(LW, 1, E_MWB, "lw_wb");
        check_count("count_after_timeouts");

        // A second TO-long stall in MEM_READ times out too (counter cleared).
        step(LW, 1, E_FETCH, "lw2_fetch"); step(LW, 1, E_DECODE, "lw2_dec");
        step(LW, 1, E_MADDR, "lw2_addr");
        for (int i = 1; i < TO; i++) step(LW, 0, E_MRD_W, $sformatf("lw2_wait%0d", i));
        step(LW, 0, E_MRD_TO, "lw2_timeout");

        // Reset mid MEM_WRITE: strobes drop without a clock edge.
        step(SW, 1, E_FETCH, "rst_fetch"); step(SW, 1, E_DECODE, "rst_dec");
        step(SW, 1, E_MADDR, "rst_addr");
        opcode = SW; mem_ready = 1'b0;
        sb.push_back(E_MWR_W);
        #1;
        check_word("rst_in_mem_write");
        reset = 1'b1;
        #1;
        sb.push_back(E_IDLE);
        check_word("async_reset_outputs");
        model_cnt = 0;
        check_count("count_after_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(RT, 1, E_IDLE, "post_rst_idle");
        step(RT, 1, E_FETCH, "post_rst_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the non-pipelined MIPS datapath over multiple cycles.
- Drives PC, IR, register-file, ALU-mux and memory enables for R-type, lw, sw, beq and j.
- Handshakes with a shared instruction/data memory through mem_ready, with a wait-state timeout.
- Sits between the opcode field of the IR and the datapath muxes; replaces the single-cycle decoder in the multicycle build.

Parameters:
- TIMEOUT_CYCLES, 16, max consecutive wait cycles (mem_ready=0) in a memory state before abort; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  0 PC addresses memory, 1 ALUOut addresses memory
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  1 selects rd, 0 selects rt
- memto_reg  out  1  1 selects MDR, 0 selects ALUOut
- reg_write  out  1  register-file write
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  11 add, 01 subtract, 00 R-type funct decode
- sign_or_zero  out  1  constant 1 (sign-extend)
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- mem_timeout  out  1  one-cycle pulse on wait-state abort

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP.
- Reset: state=IDLE, wait counter=0. All outputs 0 except sign_or_zero=1.
- IDLE lasts exactly one cycle, then FETCH.
- Outputs decode from the state register only. The exception is FETCH, where pc_write and ir_write are ANDed with mem_ready.
- Signals not listed for a state are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=11, pc_source=00, ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=11 (branch target to ALUOut).
  - Opcode 000000 -> EXECUTE; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP.
  - Any other opcode: illegal_op=1, next state FETCH, no writes.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=11. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, memto_reg=1, reg_dst=0, instr_done=1, next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Waits for mem_ready; instr_done=1 in the cycle mem_ready=1, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=00, next ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, instr_done=1, next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1, next FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1, next FETCH.
- Latency with mem_ready always 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
- Wait counter:
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on any state change or on mem_ready=1.
  - When it reaches TIMEOUT_CYCLES: mem_timeout=1 that cycle, next state FETCH, and no pc_write, ir_write, reg_write or instr_done.
  - A timeout in FETCH retries the fetch with the PC unchanged.
- If mem_ready=1 in the same cycle the counter reaches its limit, mem_ready wins: normal transition, no mem_timeout.
- Reset asserted mid-instruction: immediate return to IDLE, with all strobes deasserted asynchronously.

Optional Feature:
- Macro MC_INSTR_COUNT_EN.
- When defined: adds output instr_count [31:0].
  - Reset to 0; increments on each instr_done pulse; wraps from 0xFFFFFFFF to 0.
  - Does not count illegal or timed-out instructions.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then R-type opcode 000000 with mem_ready=1 -> IDLE, FETCH, DECODE, EXECUTE, ALU_WB; reg_dst=1 and reg_write=1 only in cycle 4; instr_done pulse in cycle 4.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles, mem_read=1 and i_or_d=1 throughout; MEM_WB then asserts memto_reg=1 and reg_write=1; no mem_timeout.
- sw (101011) with mem_ready=0 for TIMEOUT_CYCLES=16 cycles -> mem_timeout pulse in cycle 16, return to FETCH, mem_write drops, no instr_done.
- beq (000100), then j (000010) -> 3 cycles each; pc_write_cond=1 with pc_source=01, then pc_write=1 with pc_source=10; alu_op=01 in BRANCH.
- Opcode 111111 -> illegal_op pulse in DECODE, next FETCH, reg_write and mem_write never asserted.
- Reset asserted during MEM_WRITE -> mem_write=0 immediately, state IDLE, instr_count=0 when MC_INSTR_COUNT_EN is defined.
